seq_bin_to_bcd: RTL

- Multi-cycle, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Generalises the combinational two-digit converter to:
  - any input width
  - any digit count
  - optional signed (two's complement) input
  - start/ready/done handshake
  - overflow flag
- Feeds seven-segment display drivers and result registers of the arithmetic units (adders, subtractors) in the lab designs.

---
 rtl/seq_bin_to_bcd.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Parametrised in input width, digit count and signedness. Uses a start/ready/done
// handshake and flags results that do not fit in DIGITS decimal digits.

// One BCD digit's add-3 correction, applied before every shift.
module seq_bin_to_bcd_digit (
  input  logic [3:0] d,
  input  logic [3:0] q_unused_dummy_n,
  output logic [3:0] q
);
  logic unused_ok;
  // Only 5..9 get corrected, so the 4-bit add never wraps.
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
  assign unused_ok = &q_unused_dummy_n;
endmodule

module seq_bin_to_bcd #(
  parameter int N      = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N-1:0]          bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [N-1:0]  shreg, shreg_sh, mag;
  logic [W-1:0]  work, adj, work_sh;
  logic [CW-1:0] cnt;
  logic          out_bit, pend, sign_q, in_neg, accept, last_step;

  // Per-digit add-3 stage across the whole working register.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      seq_bin_to_bcd_digit u_dig (
        .d                (work[4*g +: 4]),
        .q_unused_dummy_n (4'hF),
        .q                (adj[4*g +: 4])
      );
    end
  endgenerate

  // Bit leaving the top of the working register is lost magnitude: overflow.
  assign {out_bit, work_sh, shreg_sh} = {adj, shreg, 1'b0};

  // Negative inputs convert their magnitude; -2^(N-1) maps to 2^(N-1).
  assign in_neg    = (SIGNED != 0) && bin[N-1];
  assign mag       = in_neg ? (~bin + N'(1)) : bin;
  assign accept    = (state == IDLE) && start;
  assign last_step = (state == CONVERT) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: run exactly N steps per accepted request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)        state_nxt = CONVERT;
      CONVERT: if (cnt == LAST)  state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready = (state == IDLE);
    busy  = (state == CONVERT);
  end

  // Working datapath: load on accept, one shift-and-correct step per busy cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg  <= '0;
      work   <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
      sign_q <= 1'b0;
    end else if (accept) begin
      shreg  <= mag;
      work   <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
      sign_q <= in_neg;
    end else if (state == CONVERT) begin
      shreg  <= shreg_sh;
      work   <= work_sh;
      pend   <= pend | out_bit;
      cnt    <= cnt + CW'(1);
    end
  end

  // Result registers: updated only on the final step, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      neg      <= 1'b0;
    end else begin
      done <= last_step;
      if (last_step) begin
        bcd      <= work_sh;
        overflow <= pend | out_bit;
        neg      <= sign_q;
      end
    end
  end
endmodule
